// File: rtl/counter_sched.sv
// Round-robin scheduler sharing one loadable up-counter between NumReq requesters.
// Each grant clears the counter, counts to the owner's latched length, then pulses done.
module counter_sched #(
  parameter int unsigned Width  = 8,
  parameter int unsigned NumReq = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NumReq-1:0]       req_i,
  input  logic [NumReq*Width-1:0] len_i,
  output logic [NumReq-1:0]       gnt_o,
  output logic [NumReq-1:0]       done_o,
  output logic                    busy_o,
  output logic                    cnt_en_o,
  output logic                    cnt_load_o,
  output logic [Width-1:0]        cnt_data_o,
  input  logic [Width-1:0]        cnt_i
);

  localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [IdxW-1:0]   ptr_q, ptr_d;
  logic [Width-1:0]  len_q, len_d;

  logic              found;
  logic [IdxW-1:0]   win;
  logic [IdxW:0]     cand;
  logic [NumReq-1:0] owner;

  // Search ptr, ptr+1, ... wrapping, so the last winner ranks behind everyone else.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      cand = {1'b0, ptr_q} + (IdxW+1)'(i);
      if (cand >= (IdxW+1)'(NumReq)) begin
        cand = cand - (IdxW+1)'(NumReq);
      end
      if (!found && req_i[cand]) begin
        found = 1'b1;
        win   = cand[IdxW-1:0];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    ptr_d      = ptr_q;
    len_d      = len_q;
    cnt_en_o   = 1'b0;
    cnt_load_o = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          idx_d   = win;
          len_d   = len_i[win*Width +: Width];
          state_d = StLoad;
        end
      end
      StLoad: begin
        cnt_en_o   = 1'b1;
        cnt_load_o = 1'b1;
        state_d    = StRun;
      end
      StRun: begin
        // Enable drops in the same cycle the target is seen so the counter holds at len_q.
        if (cnt_i != len_q) begin
          cnt_en_o = 1'b1;
        end else begin
          state_d = StDone;
        end
      end
      StDone: begin
        ptr_d   = (idx_q == IdxW'(NumReq - 1)) ? '0 : idx_q + IdxW'(1);
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      idx_q   <= '0;
      ptr_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      len_q   <= len_d;
    end
  end

  always_comb begin
    owner        = '0;
    owner[idx_q] = 1'b1;
  end

  assign gnt_o      = (state_q != StIdle) ? owner : '0;
  assign done_o     = (state_q == StDone) ? owner : '0;
  assign busy_o     = (state_q != StIdle);
  assign cnt_data_o = '0;

endmodule

// File: tb/tb_counter_sched.sv
// Directed bench for counter_sched with a behavioural model of the shared counter.
module tb_counter_sched;

  localparam int unsigned Width  = 8;
  localparam int unsigned NumReq = 4;

  logic                    clk = 1'b0;
  logic                    rst_i;
  logic [NumReq-1:0]       req_i;
  logic [NumReq*Width-1:0] len_i;
  logic [NumReq-1:0]       gnt_o, done_o;
  logic                    busy_o, cnt_en_o, cnt_load_o;
  logic [Width-1:0]        cnt_data_o;
  logic [Width-1:0]        cnt = '0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Shared counter: load wins over enable, free wrap on overflow.
  always @(posedge clk) begin
    if (cnt_load_o)    cnt <= cnt_data_o;
    else if (cnt_en_o) cnt <= cnt + 8'd1;
  end

  counter_sched #(.Width(Width), .NumReq(NumReq)) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .req_i      (req_i),
    .len_i      (len_i),
    .gnt_o      (gnt_o),
    .done_o     (done_o),
    .busy_o     (busy_o),
    .cnt_en_o   (cnt_en_o),
    .cnt_load_o (cnt_load_o),
    .cnt_data_o (cnt_data_o),
    .cnt_i      (cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    req_i = '0;
    rst_i = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
  endtask

  task automatic test_reset();
    req_i = '0;
    len_i = '0;
    rst_i = 1'b1;
    #2;
    n_tests++;
    if ({gnt_o, done_o, busy_o, cnt_en_o, cnt_load_o} !== 11'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b want 0", {gnt_o, done_o, busy_o, cnt_en_o, cnt_load_o});
    end
    n_tests++;
    if (cnt_data_o !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_data: got %0d want 0", cnt_data_o);
    end
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
  endtask

  task automatic test_single();
    int en_cycles = 0;
    len_i = '0;
    len_i[0 +: 8] = 8'd5;
    req_i = 4'b0001;
    tick();  // cycle 1: LOAD
    n_tests++;
    if ({gnt_o, done_o, busy_o, cnt_en_o, cnt_load_o} !== {4'b0001, 4'b0000, 3'b111}) begin
      n_fail++;
      $display("FAIL single_load: got %b want 00010000111",
               {gnt_o, done_o, busy_o, cnt_en_o, cnt_load_o});
    end
    req_i = '0;
    for (int k = 0; k < 6; k++) begin  // cycles 2..7: RUN
      tick();
      if (cnt_en_o) en_cycles++;
      n_tests++;
      if (cnt_en_o !== (k < 5) || gnt_o !== 4'b0001 || cnt_load_o !== 1'b0 || done_o !== 4'b0) begin
        n_fail++;
        $display("FAIL single_run%0d: en=%b gnt=%b load=%b done=%b want en=%b gnt=0001",
                 k, cnt_en_o, gnt_o, cnt_load_o, done_o, (k < 5));
      end
    end
    n_tests++;
    if (en_cycles != 5) begin
      n_fail++;
      $display("FAIL single_en_cycles: got %0d want 5", en_cycles);
    end
    tick();  // cycle 8: DONE
    n_tests++;
    if (done_o !== 4'b0001 || gnt_o !== 4'b0001 || cnt !== 8'd5 || cnt_en_o !== 1'b0) begin
      n_fail++;
      $display("FAIL single_done: done=%b gnt=%b cnt=%0d en=%b want 0001 0001 5 0",
               done_o, gnt_o, cnt, cnt_en_o);
    end
    tick();  // cycle 9
    n_tests++;
    if ({gnt_o, done_o, busy_o} !== 9'b0) begin
      n_fail++;
      $display("FAIL single_idle: got %b want 0", {gnt_o, done_o, busy_o});
    end
  endtask

  task automatic test_zero_len();
    len_i = '0;
    req_i = 4'b0100;
    tick();
    n_tests++;
    if (gnt_o !== 4'b0100 || cnt_load_o !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_load: gnt=%b load=%b want 0100 1", gnt_o, cnt_load_o);
    end
    req_i = '0;
    tick();
    n_tests++;
    if (cnt_en_o !== 1'b0 || cnt_load_o !== 1'b0 || busy_o !== 1'b1 || cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL zero_run: en=%b load=%b busy=%b cnt=%0d want 0 0 1 0",
               cnt_en_o, cnt_load_o, busy_o, cnt);
    end
    tick();
    n_tests++;
    if (done_o !== 4'b0100 || cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL zero_done: done=%b cnt=%0d want 0100 0", done_o, cnt);
    end
    tick();
    n_tests++;
    if (busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_idle: busy=%b want 0", busy_o);
    end
  endtask

  task automatic test_round_robin();
    logic [NumReq-1:0] exp;
    apply_reset();
    len_i = {8'd2, 8'd2, 8'd2, 8'd2};
    req_i = 4'b1111;
    tick();
    for (int j = 0; j < 5; j++) begin
      exp = 4'b0001 << (j % 4);
      n_tests++;
      if (cnt_load_o !== 1'b1 || gnt_o !== exp) begin
        n_fail++;
        $display("FAIL rr_grant%0d: load=%b gnt=%b want 1 %b", j, cnt_load_o, gnt_o, exp);
      end
      if (j == 4) req_i = '0;
      for (int k = 1; k <= 4; k++) begin
        tick();
        n_tests++;
        if (done_o !== ((k == 4) ? exp : 4'b0) || gnt_o !== exp) begin
          n_fail++;
          $display("FAIL rr_job%0d_c%0d: done=%b gnt=%b want done=%b gnt=%b",
                   j, k, done_o, gnt_o, ((k == 4) ? exp : 4'b0), exp);
        end
      end
      if (j < 4) begin
        tick();
        n_tests++;
        if (busy_o !== 1'b0 || gnt_o !== 4'b0) begin
          n_fail++;
          $display("FAIL rr_gap%0d: busy=%b gnt=%b want 0 0000", j, busy_o, gnt_o);
        end
        tick();
      end
    end
    tick();
    n_tests++;
    if ({gnt_o, busy_o} !== 5'b0) begin
      n_fail++;
      $display("FAIL rr_end: got %b want 0", {gnt_o, busy_o});
    end
  endtask

  task automatic test_nonpreempt();
    int  runs    = 0;
    int  dones   = 0;
    bit  changed = 1'b0;
    len_i = '0;
    len_i[8 +: 8] = 8'd10;
    req_i = 4'b0010;
    tick();
    n_tests++;
    if (gnt_o !== 4'b0010 || cnt_load_o !== 1'b1) begin
      n_fail++;
      $display("FAIL np_load: gnt=%b load=%b want 0010 1", gnt_o, cnt_load_o);
    end
    for (int c = 0; c < 30; c++) begin
      tick();
      if (done_o != 4'b0) begin
        dones++;
        n_tests++;
        if (done_o !== 4'b0010 || cnt !== 8'd10) begin
          n_fail++;
          $display("FAIL np_done: done=%b cnt=%0d want 0010 10", done_o, cnt);
        end
      end else if (busy_o) begin
        runs++;
      end
      if (runs == 3 && !changed) begin
        changed = 1'b1;
        len_i[8 +: 8] = 8'd2;
        req_i = '0;
      end
    end
    n_tests++;
    if (runs != 11 || dones != 1) begin
      n_fail++;
      $display("FAIL np_counts: runs=%0d dones=%0d want 11 1", runs, dones);
    end
  endtask

  task automatic test_reset_mid();
    bit reached = 1'b0;
    int dones   = 0;
    len_i = '0;
    len_i[0 +: 8] = 8'd9;
    req_i = 4'b0001;
    tick();
    req_i = '0;
    for (int c = 0; c < 20 && !reached; c++) begin
      tick();
      if (busy_o && cnt == 8'd4) reached = 1'b1;
    end
    n_tests++;
    if (!reached) begin
      n_fail++;
      $display("FAIL rm_reach: cnt=%0d busy=%b want cnt 4 in RUN", cnt, busy_o);
    end
    #3 rst_i = 1'b1;
    #1;
    n_tests++;
    if ({gnt_o, done_o, busy_o, cnt_en_o} !== 10'b0) begin
      n_fail++;
      $display("FAIL rm_async: gnt=%b done=%b busy=%b en=%b want all 0",
               gnt_o, done_o, busy_o, cnt_en_o);
    end
    #2 rst_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (done_o != 4'b0) dones++;
    end
    n_tests++;
    if (dones != 0 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rm_silent: dones=%0d busy=%b want 0 0", dones, busy_o);
    end
    len_i[8 +: 8] = 8'd1;
    req_i = 4'b0110;
    tick();
    n_tests++;
    if (gnt_o !== 4'b0010) begin
      n_fail++;
      $display("FAIL rm_regrant: gnt=%b want 0010", gnt_o);
    end
    req_i = '0;
    repeat (4) tick();
  endtask

  task automatic test_max_len();
    int  cyc      = 0;
    int  runs     = 0;
    int  done_cyc = -1;
    bit  wrapped  = 1'b0;
    logic [Width-1:0] done_cnt = '0;
    apply_reset();
    len_i = '0;
    len_i[0 +: 8] = 8'd255;
    req_i = 4'b0001;
    for (int c = 0; c < 300 && done_cyc < 0; c++) begin
      tick();
      cyc++;
      if (cyc == 1) req_i = '0;
      if (cnt_load_o) begin
        // LOAD cycle, nothing to count
      end else if (done_o != 4'b0) begin
        done_cyc = cyc;
        done_cnt = cnt;
      end else if (busy_o) begin
        runs++;
        if (runs > 1 && cnt == 8'd0) wrapped = 1'b1;
      end
    end
    n_tests++;
    if (runs != 256 || done_cyc != 258) begin
      n_fail++;
      $display("FAIL max_timing: runs=%0d done_cycle=%0d want 256 258", runs, done_cyc);
    end
    n_tests++;
    if (done_cnt !== 8'd255 || wrapped) begin
      n_fail++;
      $display("FAIL max_nowrap: cnt=%0d wrapped=%b want 255 0", done_cnt, wrapped);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_zero_len();
    test_round_robin();
    test_nonpreempt();
    test_reset_mid();
    test_max_len();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
